ct_piu_l2pmp_apb_bridge: RTL and testbench

CT_PIU_L2PMP_APB_BRIDGE -- requirements
Module: ct_piu_l2pmp_apb_bridge

---
 rtl/ct_piu_l2pmp_apb_bridge.sv | 125 ++++++++++++
 tb/tb_ct_piu_l2pmp_apb_bridge.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ct_piu_l2pmp_apb_bridge.sv
// Register-request to APB bridge for the PIU L2 PMP slave.
// One transfer in flight; misaligned requests complete with error without touching APB.
module ct_piu_l2pmp_apb_bridge #(
    parameter logic [7:0] TO_CYCLES = 8'd255
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        req_vld,
    input  logic        req_write,
    input  logic [11:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_rdy,
    output logic        psel_l2pmp_x,
    output logic        penable_l2pmp_x,
    output logic        pwrite_l2pmp_x,
    output logic [11:0] paddr_l2pmp_x,
    output logic [31:0] pwdata_l2pmp_x,
    input  logic        pready_l2pmp_x,
    input  logic        perr_l2pmp_x,
    input  logic [31:0] x_prdata_l2pmp,
    output logic        resp_vld,
    output logic        resp_err,
    output logic [31:0] resp_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    typedef struct packed {
        logic        write;
        logic [11:0] addr;
        logic [31:0] wdata;
    } req_t;

    state_e      state_q, state_d;
    req_t        req_q, req_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q <= IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                err_d   = 1'b0;
                rdata_d = '0;
                if (req_vld) begin
                    req_d.write = req_write;
                    req_d.addr  = req_addr;
                    req_d.wdata = req_wdata;
                    if (req_addr[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                // pready wins over a timeout landing in the same cycle
                if (pready_l2pmp_x) begin
                    err_d   = perr_l2pmp_x;
                    rdata_d = (!req_q.write && !perr_l2pmp_x) ? x_prdata_l2pmp : 32'h0;
                    state_d = RESP;
                end else if (cnt_q == TO_CYCLES) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                req_d   = '0;
                err_d   = 1'b0;
                rdata_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic apb_act;
    assign apb_act = (state_q == SETUP) || (state_q == ACCESS);

    assign req_rdy         = (state_q == IDLE) && cpurst_b;
    assign psel_l2pmp_x    = apb_act;
    assign penable_l2pmp_x = (state_q == ACCESS);
    assign pwrite_l2pmp_x  = apb_act && req_q.write;
    assign paddr_l2pmp_x   = apb_act ? req_q.addr  : 12'h0;
    assign pwdata_l2pmp_x  = apb_act ? req_q.wdata : 32'h0;

    assign resp_vld   = (state_q == RESP);
    assign resp_err   = resp_vld && err_q;
    assign resp_rdata = resp_vld ? rdata_q : 32'h0;

endmodule

// File: tb/tb_ct_piu_l2pmp_apb_bridge.sv
// Self-checking bench: directed corner cases plus random transfers against a latency/result model.
module tb_ct_piu_l2pmp_apb_bridge;

    localparam logic [7:0] TO = 8'd4;
    localparam int LIMIT = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_vld, req_write, req_rdy;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic        pready, perr;
    logic [31:0] prdata;
    logic        resp_vld, resp_err;
    logic [31:0] resp_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ct_piu_l2pmp_apb_bridge #(.TO_CYCLES(TO)) dut (
        .forever_cpuclk  (clk),
        .cpurst_b        (rst_n),
        .req_vld         (req_vld),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_rdy         (req_rdy),
        .psel_l2pmp_x    (psel),
        .penable_l2pmp_x (penable),
        .pwrite_l2pmp_x  (pwrite),
        .paddr_l2pmp_x   (paddr),
        .pwdata_l2pmp_x  (pwdata),
        .pready_l2pmp_x  (pready),
        .perr_l2pmp_x    (perr),
        .x_prdata_l2pmp  (prdata),
        .resp_vld        (resp_vld),
        .resp_err        (resp_err),
        .resp_rdata      (resp_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference: cycles from accept to resp_vld, result, and number of ACCESS cycles.
    task automatic model(input logic wr, input logic [11:0] addr, input int waits,
                         input logic pe, input logic [31:0] prd,
                         output int lat, output logic err, output logic [31:0] rd, output int acc);
        if (addr[1:0] != 2'b00) begin
            lat = 1; err = 1'b1; rd = 32'h0; acc = 0;
        end else if (waits <= int'(TO)) begin
            acc = waits + 1; lat = 3 + waits; err = pe; rd = (!wr && !pe) ? prd : 32'h0;
        end else begin
            acc = int'(TO) + 1; lat = 3 + int'(TO); err = 1'b1; rd = 32'h0;
        end
    endtask

    task automatic run_txn(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                           input int waits, input logic pe, input logic [31:0] prd,
                           input logic junk, input int rst_at);
        int lat, acc, got_lat, a, psel_cnt;
        logic err;
        logic [31:0] rd;
        model(wr, addr, waits, pe, prd, lat, err, rd, acc);
        @(negedge clk);
        chk("rdy_before", 32'(req_rdy), 32'd1);
        req_vld = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        got_lat = 0; a = 0; psel_cnt = 0;
        for (int k = 1; k <= LIMIT && got_lat == 0; k++) begin
            @(negedge clk);
            if (junk) begin
                req_vld = 1'b1; req_write = 1'($urandom);
                req_addr = 12'($urandom); req_wdata = $urandom;
            end else begin
                req_vld = 1'b0;
            end
            if (psel) begin
                psel_cnt++;
                chk("paddr", 32'(paddr), 32'(addr));
                chk("pwrite", 32'(pwrite), 32'(wr));
                chk("pwdata", pwdata, wd);
            end
            if (psel && penable) begin
                if (a == rst_at) begin
                    rst_n = 1'b0;
                    #1;
                    chk("rst_psel", 32'(psel), 32'd0);
                    chk("rst_penable", 32'(penable), 32'd0);
                    chk("rst_resp_vld", 32'(resp_vld), 32'd0);
                    @(negedge clk);
                    rst_n = 1'b1; pready = 1'b0;
                    repeat (6) begin
                        @(negedge clk);
                        chk("post_rst_no_resp", 32'(resp_vld), 32'd0);
                        chk("post_rst_psel", 32'(psel), 32'd0);
                    end
                    chk("post_rst_rdy", 32'(req_rdy), 32'd1);
                    return;
                end
                pready = (a == waits);
                perr   = (a == waits) ? pe  : 1'($urandom);
                prdata = (a == waits) ? prd : $urandom;
                a++;
            end else begin
                pready = 1'($urandom); perr = 1'($urandom); prdata = $urandom;
            end
            if (resp_vld) begin
                got_lat = k;
                chk("resp_err", 32'(resp_err), 32'(err));
                chk("resp_rdata", resp_rdata, rd);
                chk("psel_in_resp", 32'(psel), 32'd0);
                req_vld = 1'b0;
            end
        end
        chk("latency", 32'(got_lat), 32'(lat));
        chk("access_cycles", 32'(a), 32'(acc));
        chk("psel_cycles", 32'(psel_cnt), 32'((acc > 0) ? acc + 1 : 0));
        @(negedge clk);
        chk("idle_psel", 32'(psel), 32'd0);
        chk("idle_rdy", 32'(req_rdy), 32'd1);
        chk("idle_resp_vld", 32'(resp_vld), 32'd0);
        pready = 1'b0; perr = 1'b0; prdata = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0; req_vld = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        pready = 1'b0; perr = 1'b0; prdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_psel0", 32'(psel), 32'd0);
        chk("rst_resp0", 32'(resp_vld), 32'd0);
        chk("rst_pwdata0", pwdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rdy1", 32'(req_rdy), 32'd1);

        run_txn(1'b0, 12'h010, 32'h0,          0, 1'b0, 32'hDEADBEEF, 1'b0, -1);
        run_txn(1'b1, 12'h020, 32'h0000_00FF,  3, 1'b0, 32'h1234_5678, 1'b0, -1);
        run_txn(1'b0, 12'h030, 32'h0,        255, 1'b0, 32'h0,        1'b0, -1);
        run_txn(1'b0, 12'h034, 32'h0, int'(TO), 1'b0, 32'hCAFE_F00D, 1'b0, -1);
        run_txn(1'b0, 12'h040, 32'h0,          1, 1'b1, 32'h5555_AAAA, 1'b0, -1);
        run_txn(1'b1, 12'h013, 32'hA5A5_A5A5,  0, 1'b0, 32'h0,        1'b0, -1);
        run_txn(1'b1, 12'h050, 32'h1111_2222,  5, 1'b0, 32'h0,        1'b0, 2);
        run_txn(1'b0, 12'h054, 32'h0,          2, 1'b0, 32'h0BAD_F00D, 1'b1, -1);

        for (int i = 0; i < 60; i++) begin
            logic [11:0] ad;
            ad = 12'($urandom);
            if ($urandom_range(3) != 0) ad[1:0] = 2'b00;
            run_txn(1'($urandom), ad, $urandom, int'($urandom_range(6)),
                    1'($urandom_range(3) == 0), $urandom, 1'($urandom), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
